// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline/memory-side bundle for the store buffer.
//   master : pipeline control and data memory model (drives requests and mem_rdata_i)
//   slave  : store_buffer itself
// Signals:
//   MemWrite_i, MemRead_i, addr_i, wdata_i, sync_i  pipeline requests
//   rdata_o, stall_o                                pipeline responses
//   mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o data memory port
//   mem_rdata_i                                     data memory read data
interface store_buffer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              MemWrite_i;
    logic              MemRead_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              sync_i;
    logic [DATA_W-1:0] rdata_o;
    logic              stall_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_write_o;
    logic              mem_read_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output MemWrite_i, MemRead_i, addr_i, wdata_i, sync_i, mem_rdata_i,
        input  rdata_o, stall_o, mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o
    );

    modport slave (
        input  MemWrite_i, MemRead_i, addr_i, wdata_i, sync_i, mem_rdata_i,
        output rdata_o, stall_o, mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: word-granular posted-write FIFO between MEM-stage control and data memory.
// Stores are absorbed into a DEPTH-entry FIFO and drained to memory in idle cycles; loads
// are forwarded from the youngest matching pending entry so they never see stale memory.
// Ports:
//   clk_i  clock (rising edge)
//   rst_i  synchronous active-high reset; pending stores are discarded
//   bus    store_buffer_if.slave (pipeline requests/responses and data memory port)
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    store_buffer_if.slave bus
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned WA_W = ADDR_W - 2;

    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    // Entry storage; validity is implied by position relative to head_q and count_q.
    logic [WA_W-1:0]   ent_addr_q [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic is_store;
    logic is_load;
    logic is_idle;
    logic empty;
    logic full;
    logic sync_act;
    logic drain;
    logic push;
    logic rd_issue;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PW-1:0]     fwd_idx;

    // A request with both MemWrite_i and MemRead_i set behaves as a store.
    assign is_store = bus.MemWrite_i;
    assign is_load  = bus.MemRead_i & ~bus.MemWrite_i;
    assign is_idle  = ~bus.MemRead_i & ~bus.MemWrite_i;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CountFull);

    // A fence only matters while something is pending; once empty the request proceeds.
    assign sync_act = bus.sync_i & ~empty;

    // Drain in idle cycles, during a fence, or forced when a store hits a full buffer.
    assign drain    = ~rst_i & ~empty & (sync_act | is_idle | (is_store & full));
    assign push     = ~rst_i & ~sync_act & is_store & ~full;
    assign rd_issue = ~rst_i & ~sync_act & is_load;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (ent_addr_q[fwd_idx] == bus.addr_i[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data_q[fwd_idx];
            end
        end
    end

    assign bus.stall_o     = ~rst_i & (sync_act | (is_store & full));
    assign bus.mem_write_o = drain;
    assign bus.mem_read_o  = rd_issue;
    assign bus.mem_wdata_o = drain ? ent_data_q[head_q] : '0;
    assign bus.mem_addr_o  = drain    ? {ent_addr_q[head_q], 2'b00} :
                             rd_issue ? bus.addr_i : '0;
    assign bus.rdata_o     = rd_issue ? (fwd_hit ? fwd_data : bus.mem_rdata_i) : '0;

    // push and drain are mutually exclusive: a store either enqueues or forces a drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (push) begin
            ent_addr_q[tail_q] <= bus.addr_i[ADDR_W-1:2];
            ent_data_q[tail_q] <= bus.wdata_i;
            tail_q             <= tail_q + 1'b1;
            count_q            <= count_q + 1'b1;
        end else if (drain) begin
            head_q  <= head_q + 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer with a queue-based reference model.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(
        .DEPTH (DEPTH),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [29:0] wa;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending stores live in a queue, oldest at the front.
    logic        m_wr, m_rd, m_sync, m_load, m_idle, m_syncact, m_drain, m_hit;
    logic [31:0] m_rdata, m_addr, m_wdata;
    int          m_sz;

    always @(negedge clk) begin
        if (chk_en) begin
            m_wr      = bus.MemWrite_i;
            m_rd      = bus.MemRead_i;
            m_sync    = bus.sync_i;
            m_sz      = q.size();
            m_load    = m_rd && !m_wr;
            m_idle    = !m_rd && !m_wr;
            m_syncact = m_sync && m_sz > 0;
            m_drain   = !rst && m_sz > 0 && (m_syncact || m_idle || (m_wr && m_sz == DEPTH));
            m_hit     = 1'b0;
            m_rdata   = bus.mem_rdata_i;
            for (int i = 0; i < m_sz; i++) begin
                if (q[i].wa == bus.addr_i[31:2]) begin
                    m_hit   = 1'b1;
                    m_rdata = q[i].d;
                end
            end
            m_addr  = 32'h0;
            m_wdata = 32'h0;
            if (m_drain) begin
                m_addr  = {q[0].wa, 2'b00};
                m_wdata = q[0].d;
            end else if (!rst && m_load && !m_syncact) begin
                m_addr = bus.addr_i;
            end
            chk("stall", {31'b0, bus.stall_o},
                {31'b0, !rst && (m_syncact || (m_wr && m_sz == DEPTH))});
            chk("mem_write", {31'b0, bus.mem_write_o}, {31'b0, m_drain});
            chk("mem_read", {31'b0, bus.mem_read_o}, {31'b0, !rst && m_load && !m_syncact});
            chk("mem_addr", bus.mem_addr_o, m_addr);
            chk("mem_wdata", bus.mem_wdata_o, m_wdata);
            if (rst || (m_wr && m_rd))
                chk("rdata_zero", bus.rdata_o, 32'h0);
            else if (m_load && !m_syncact)
                chk("rdata", bus.rdata_o, m_rdata);
        end
    end

    always @(posedge clk) begin
        ent_t e;
        int   sz;
        bit   sa;
        if (rst) begin
            q.delete();
        end else begin
            sz = q.size();
            sa = bus.sync_i && sz > 0;
            if (sz > 0 && (sa || (!bus.MemWrite_i && !bus.MemRead_i) ||
                           (bus.MemWrite_i && sz == DEPTH))) begin
                void'(q.pop_front());
            end else if (bus.MemWrite_i && !sa && sz < DEPTH) begin
                e.wa = bus.addr_i[31:2];
                e.d  = bus.wdata_i;
                q.push_back(e);
            end
        end
    end

    // Apply one cycle of stimulus just after the rising edge; return just after the
    // following falling edge so literal checks see settled outputs.
    task automatic step(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic s, input logic [31:0] mr,
                        input logic r);
        @(posedge clk);
        #1;
        bus.MemWrite_i  = wr;
        bus.MemRead_i   = rd;
        bus.addr_i      = a;
        bus.wdata_i     = d;
        bus.sync_i      = s;
        bus.mem_rdata_i = mr;
        rst             = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.MemWrite_i  = 1'b0;
        bus.MemRead_i   = 1'b0;
        bus.addr_i      = '0;
        bus.wdata_i     = '0;
        bus.sync_i      = 1'b0;
        bus.mem_rdata_i = '0;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset with a store request present: everything quiet.
        step(1, 0, 32'h8, 32'h1, 0, 32'h0, 1);
        chk("rst_stall", {31'b0, bus.stall_o}, 32'h0);
        chk("rst_mem_write", {31'b0, bus.mem_write_o}, 32'h0);
        step(0, 1, 32'h8, 32'h0, 0, 32'h77, 1);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_mem_read", {31'b0, bus.mem_read_o}, 32'h0);

        // Single store then drain.
        step(1, 0, 32'h8, 32'hA5, 0, 32'h0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        chk("t1_write", {31'b0, bus.mem_write_o}, 32'h1);
        chk("t1_addr", bus.mem_addr_o, 32'h8);
        chk("t1_wdata", bus.mem_wdata_o, 32'hA5);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        chk("t1_empty", {31'b0, bus.mem_write_o}, 32'h0);

        // Youngest-entry forwarding, then in-order drain.
        step(1, 0, 32'h4, 32'h11, 0, 32'h0, 0);
        step(1, 0, 32'h4, 32'h22, 0, 32'h0, 0);
        step(0, 1, 32'h4, 32'h0, 0, 32'h999, 0);
        chk("t2_fwd", bus.rdata_o, 32'h22);
        chk("t2_read", {31'b0, bus.mem_read_o}, 32'h1);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        chk("t2_drain0", bus.mem_wdata_o, 32'h11);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        chk("t2_drain1", bus.mem_wdata_o, 32'h22);

        // Fill to DEPTH, fifth store stalls once with a forced drain.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'(i * 4), 32'(i + 1), 0, 32'h0, 0);
            chk("t3_nostall", {31'b0, bus.stall_o}, 32'h0);
        end
        step(1, 0, 32'h10, 32'h5, 0, 32'h0, 0);
        chk("t3_stall", {31'b0, bus.stall_o}, 32'h1);
        chk("t3_forced_addr", bus.mem_addr_o, 32'h0);
        chk("t3_forced_data", bus.mem_wdata_o, 32'h1);
        step(1, 0, 32'h10, 32'h5, 0, 32'h0, 0);
        chk("t3_accept", {31'b0, bus.stall_o}, 32'h0);
        step(0, 1, 32'h10, 32'h0, 0, 32'hBAD, 0);
        chk("t3_fwd", bus.rdata_o, 32'h5);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
            chk("t3_drain_addr", bus.mem_addr_o, 32'((i + 1) * 4));
            chk("t3_drain_data", bus.mem_wdata_o, 32'(i + 2));
        end
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        chk("t3_drained", {31'b0, bus.mem_write_o}, 32'h0);

        // Load with empty buffer goes to memory.
        step(0, 1, 32'h1C, 32'h0, 0, 32'hDEAD, 0);
        chk("t4_rdata", bus.rdata_o, 32'hDEAD);
        chk("t4_nowrite", {31'b0, bus.mem_write_o}, 32'h0);

        // Fence with a load pending: three stall cycles, then the load proceeds.
        step(1, 0, 32'h20, 32'hA, 0, 32'h0, 0);
        step(1, 0, 32'h24, 32'hB, 0, 32'h0, 0);
        step(1, 0, 32'h28, 32'hC, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h20, 32'h0, 1, 32'h5555, 0);
            chk("t5_stall", {31'b0, bus.stall_o}, 32'h1);
            chk("t5_addr", bus.mem_addr_o, 32'h20 + 32'(i * 4));
            chk("t5_data", bus.mem_wdata_o, 32'hA + 32'(i));
        end
        step(0, 1, 32'h20, 32'h0, 1, 32'h5555, 0);
        chk("t5_release", {31'b0, bus.stall_o}, 32'h0);
        chk("t5_rdata", bus.rdata_o, 32'h5555);

        // Reset discards pending stores.
        step(1, 0, 32'h30, 32'hE, 0, 32'h0, 0);
        step(1, 0, 32'h34, 32'hF, 0, 32'h0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
            chk("t6_nowrite", {31'b0, bus.mem_write_o}, 32'h0);
        end
        step(0, 1, 32'h30, 32'h0, 0, 32'h1234, 0);
        chk("t6_rdata", bus.rdata_o, 32'h1234);
        step(0, 1, 32'h34, 32'h0, 0, 32'h4321, 0);
        chk("t6_rdata2", bus.rdata_o, 32'h4321);

        // Illegal read+write acts as a store with rdata forced to zero.
        step(1, 1, 32'h40, 32'h77, 0, 32'hFFFF, 0);
        chk("t7_rdata", bus.rdata_o, 32'h0);
        chk("t7_noread", {31'b0, bus.mem_read_o}, 32'h0);
        step(0, 1, 32'h40, 32'h0, 0, 32'h0, 0);
        chk("t7_fwd", bus.rdata_o, 32'h77);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        chk("t7_drain", bus.mem_addr_o, 32'h40);

        // Fence on an empty buffer does not stall.
        step(0, 0, 32'h0, 32'h0, 1, 32'h0, 0);
        chk("t8_nostall", {31'b0, bus.stall_o}, 32'h0);
        step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular posted-write buffer between the MEM-stage pipeline control and the data memory.
- Absorbs stores into a small FIFO so the pipeline does not wait on the memory write port.
- Drains stores into the data memory in idle cycles.
- Forwards buffered data to younger loads that hit a pending entry, so loads never see stale memory.

Parameters:
DEPTH, 4, number of buffer entries (power of two, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, data word width

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
MemWrite_i  input  1  pipeline store request this cycle
MemRead_i  input  1  pipeline load request this cycle
addr_i  input  ADDR_W  byte address of load/store (word-aligned; bits [1:0] ignored)
wdata_i  input  DATA_W  store data
sync_i  input  1  fence request: hold pipeline until buffer empty
rdata_o  output  DATA_W  load data (combinational)
stall_o  output  1  pipeline must hold current MEM instruction
mem_addr_o  output  ADDR_W  data memory address
mem_write_o  output  1  data memory write enable
mem_read_o  output  1  data memory read enable
mem_wdata_o  output  DATA_W  data memory write data
mem_rdata_i  input  DATA_W  data memory read data (combinational from mem_addr_o)

Behaviour:
- Storage: DEPTH entries of {word address = addr[ADDR_W-1:2], data}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- Reset: count=0, pointers=0, all entries invalid. Pending stores are discarded, never written.
- During reset: stall_o=0, mem_write_o=0, mem_read_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0.
- Cycle classes, decided combinationally each cycle:
  - LOAD: MemRead_i=1, MemWrite_i=0.
  - STORE: MemWrite_i=1, MemRead_i=0.
  - IDLE: both 0.
  - ILLEGAL: both 1. Treated as STORE; rdata_o=0.
- LOAD:
  - mem_read_o=1, mem_addr_o=addr_i.
  - rdata_o = data of the youngest valid entry whose word address matches; otherwise mem_rdata_i.
  - No drain this cycle; stall_o=0.
- STORE, not full: enqueue {addr, wdata} at tail on the clock edge. No drain, stall_o=0, mem_write_o=0.
- STORE, full (count=DEPTH):
  - stall_o=1; forced drain of head this cycle; store not enqueued.
  - Next cycle count=DEPTH-1, the held store is accepted.
  - Exactly one stall cycle per full-store event.
- IDLE, count>0:
  - mem_write_o=1, mem_addr_o={head word addr,2'b00}, mem_wdata_o=head data.
  - Head popped on the clock edge; one word drained per cycle.
- IDLE, count=0: all memory outputs 0.
- Drain outputs: whenever no write is issued, mem_write_o=0 and mem_wdata_o=0. When neither read nor write is issued, mem_addr_o=0.
- sync_i=1 with count>0:
  - stall_o=1; drain proceeds every cycle as if IDLE, even if MemRead_i/MemWrite_i are asserted, which are ignored.
  - stall_o drops combinationally in the cycle count=0.
- Store to an address already buffered: new entry appended; no merging. Memory receives both writes in program order.
- Count never exceeds DEPTH or underflows; simultaneous push/pop never occurs by construction.
- Latency: store-to-memory at least 1 cycle after acceptance; load forwarding is zero-latency.

Test Plan:
- Reset, then STORE addr=0x8 data=0xA5, then IDLE → mem_write_o=1, mem_addr_o=0x8, mem_wdata_o=0xA5 in the IDLE cycle; count returns to 0.
- STORE 0x4=0x11, STORE 0x4=0x22, LOAD 0x4 → rdata_o=0x22 (youngest forward), mem_read_o=1. Two IDLEs drain 0x11 then 0x22 in order.
- Five back-to-back STOREs (0x0..0x10, data 1..5) with DEPTH=4 → stall_o=1 only on the fifth. Memory receives 0x0=1 that cycle; the fifth is accepted next cycle; count=4.
- LOAD 0x1C with empty buffer, mem_rdata_i=0xDEAD → rdata_o=0xDEAD, no write issued.
- Three STOREs then sync_i=1 with MemRead_i=1 → stall_o=1 for exactly 3 cycles, writes in FIFO order, stall_o=0 on the 4th.
- Two STOREs, rst_i=1 for one cycle, then IDLE ×3 → no mem_write_o pulses; LOAD of those addresses returns mem_rdata_i.
